imem_responder: RTL
===================

// Module: imem_responder
// PURPOSE
//  Responder end of the instruction-memory interface driven by the fetch stage.
//  - Holds program words in on-chip RAM.
//  - Returns the word at the fetch address after a fixed, parameterised latency, with valid and fault flags.
//  - After reset, fills the whole RAM with NOPs, then accepts program words from a boot-loader write port.
//  - Sits between the fetch stage and the boot/debug loader.
// PARAMETERS
//  DEPTH_WORDS   1024          number of 32-bit words; power of two, >= 4
//  READ_LATENCY  1             clocks from address to data; legal 1..4
//  BASE_ADDR     32'h00000000  byte address of word 0; word-aligned
//  NOP_INSTR     32'h00000013  fill and fault value (addi x0,x0,0)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous active-high reset
//  imem_addr_i    in   32  fetch byte address, sampled every cycle
//  imem_data_o    out  32  instruction for the address presented READ_LATENCY cycles earlier
//  imem_valid_o   out  1   imem_data_o is a real read (not fill, not fault)
//  imem_fault_o   out  1   that address was misaligned or out of range
//  load_valid_i   in   1   loader write request
//  load_ready_o   out  1   write accepted this cycle when valid&ready
//  load_addr_i    in   32  loader byte address
//  load_data_i    in   32  loader word
//  load_err_o     out  1   one-cycle pulse: accepted write was dropped (bad address)
//  init_done_o    out  1   NOP fill complete
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - FSM enters CLEAR; fill counter = 0.
//   - imem_data_o = NOP_INSTR; imem_valid_o, imem_fault_o, load_ready_o, load_err_o, init_done_o all 0.
//   - All read-pipe stages are invalidated.
//  FSM:
//   - CLEAR: writes NOP_INSTR at word[cnt] each cycle, cnt++. After word DEPTH_WORDS-1 -> READY.
//     Takes exactly DEPTH_WORDS cycles. load_ready_o=0. Reads return NOP with valid=0, fault=0.
//   - READY: init_done_o=1, load_ready_o=1. Stays in READY until the next reset.
//   - Reset during CLEAR restarts the fill from word 0. Partially filled contents are don't-care.
//  Address decode (fetch and load alike):
//   - off = addr - BASE_ADDR, computed in 32-bit wrap-around arithmetic; idx = off[31:2].
//   - bad = (addr[1:0] != 0) | (idx >= DEPTH_WORDS).
//  Read:
//   - Stage 0 registers {RAM[idx], good, bad} on every clk.
//   - READ_LATENCY-1 further register stages follow, always advancing; no stall.
//   - Output stage:
//     - bad: data=NOP_INSTR, valid=0, fault=1.
//     - good and READY: RAM data, valid=1, fault=0.
//     - CLEAR: data=NOP_INSTR, valid=0, fault=0.
//   - READ_LATENCY=1: data for address A, presented before edge N, appears after edge N.
//  Write (READY, load_valid_i & load_ready_o):
//   - Good address: RAM[idx] <= load_data_i at that edge.
//   - Bad address: write dropped; load_err_o=1 for the following cycle only.
//  Read/write collision:
//   - Same idx in the same cycle is read-first: the read returns the old word.
//   - A read presented one cycle after the write returns the new word.
//  Fetch address changes every cycle: one result per cycle, in order, no bubbles.
// STRUCTURE
//  - imem_pkg: IMEM_NOP constant; imem_state_e {CLEAR, READY}; imem_rd_t struct {data, valid, fault};
//    function imem_decode(addr) returning idx and bad.
//  - Sub-module imem_read_pipe #(READ_LATENCY): shift register of imem_rd_t with async reset to invalid/NOP.
//  - Top level holds the RAM array, FSM, fill counter, decode and write logic.
// TESTING
//  1 Reset, DEPTH_WORDS=16 -> init_done_o rises exactly 16 clks after rst release; all reads then return
//    32'h00000013 with valid=1.
//  2 Load 0x00500093 @0x8, then fetch 0x8, LAT=1 -> next cycle data=0x00500093, valid=1, fault=0.
//  3 Fetch 0x6, then fetch 0x40 (DEPTH=16) -> fault=1, valid=0, data=NOP for each, one cycle apart.
//  4 Load 0xDEADBEEF @0x4 and fetch 0x4 in the same cycle -> read returns the old word; a fetch the
//    next cycle returns 0xDEADBEEF.
//  5 Load @0x3 -> load_err_o pulses 1 cycle; RAM unchanged; load_ready_o stays 1.
//  6 Assert rst mid-CLEAR (cnt=7), LAT=3 -> all outputs reset immediately; fill restarts from 0.
//    Fetch 0x0, 0x4, 0x8 back-to-back -> results appear 3 cycles later, in order, one per cycle.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types, constants and address decode for the instruction-memory responder.
package imem_pkg;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

    typedef enum logic {
        CLEAR,
        READY
    } imem_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
        logic        fault;
    } imem_rd_t;

    typedef struct packed {
        logic [29:0] idx;
        logic        bad;
    } imem_dec_t;

    // The base is word-aligned, so off[1:0] equals addr[1:0].
    function automatic imem_dec_t imem_decode(input logic [31:0] addr,
                                              input logic [31:0] base_addr,
                                              input logic [31:0] depth_words);
        logic [31:0] off;
        imem_dec_t   dec;
        off     = addr - base_addr;
        dec.idx = off[31:2];
        dec.bad = (off[1:0] != 2'b00) || ({2'b00, off[31:2]} >= depth_words);
        return dec;
    endfunction

endpackage

// File: rtl/imem_read_pipe.sv
// Fixed-latency read pipeline: READ_LATENCY stages of imem_rd_t, always advancing.
module imem_read_pipe
    import imem_pkg::*;
#(
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] NOP_INSTR    = IMEM_NOP
) (
    input  logic     clk,
    input  logic     rst,
    input  imem_rd_t rd_i,
    output imem_rd_t rd_o
);

    localparam imem_rd_t RD_IDLE = '{data: NOP_INSTR, valid: 1'b0, fault: 1'b0};

    imem_rd_t stage_q [READ_LATENCY];
    imem_rd_t stage_d [READ_LATENCY];

    always_comb begin
        stage_d[0] = rd_i;
        for (int i = 1; i < READ_LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // the pre-edge value of its predecessor and the shift happens in one step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_q[i] <= RD_IDLE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign rd_o = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: NOP fill after reset, boot-loader writes, fixed-latency fetch reads.
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = IMEM_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr_i,
    output logic [31:0] imem_data_o,
    output logic        imem_valid_o,
    output logic        imem_fault_o,
    input  logic        load_valid_i,
    output logic        load_ready_o,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i,
    output logic        load_err_o,
    output logic        init_done_o
);

    localparam int               IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    logic [31:0]      ram_q [DEPTH_WORDS];

    imem_state_e      state_q, state_d;
    logic [IDX_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             init_done_q, init_done_d;
    logic             load_ready_q, load_ready_d;
    logic             load_err_q, load_err_d;

    imem_dec_t        rd_dec, ld_dec;
    imem_rd_t         rd_stage, rd_out;
    logic             load_fire;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic             unused_idx_bits;

    assign rd_dec = imem_decode(imem_addr_i, BASE_ADDR, 32'(DEPTH_WORDS));
    assign ld_dec = imem_decode(load_addr_i, BASE_ADDR, 32'(DEPTH_WORDS));
    assign unused_idx_bits = ^{rd_dec.idx[29:IDX_W], ld_dec.idx[29:IDX_W]};

    assign load_fire = (state_q == READY) && load_valid_i && load_ready_q;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        init_done_d  = init_done_q;
        load_ready_d = load_ready_q;
        load_err_d   = load_fire && ld_dec.bad;
        wr_en        = 1'b0;
        wr_idx       = fill_cnt_q;
        wr_data      = NOP_INSTR;

        case (state_q)
            CLEAR: begin
                wr_en      = 1'b1;
                fill_cnt_d = fill_cnt_q + IDX_W'(1);
                if (fill_cnt_q == LAST_IDX) begin
                    state_d      = READY;
                    init_done_d  = 1'b1;
                    load_ready_d = 1'b1;
                end
            end
            READY: begin
                if (load_fire && !ld_dec.bad) begin
                    wr_en   = 1'b1;
                    wr_idx  = ld_dec.idx[IDX_W-1:0];
                    wr_data = load_data_i;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Fault and valid are resolved before stage 0 so the pipe only carries final results;
    // a fetch sampled while still filling comes back as a plain NOP.
    always_comb begin
        rd_stage.data  = NOP_INSTR;
        rd_stage.valid = 1'b0;
        rd_stage.fault = 1'b0;
        if (state_q == READY) begin
            if (rd_dec.bad) begin
                rd_stage.fault = 1'b1;
            end else begin
                rd_stage.data  = ram_q[rd_dec.idx[IDX_W-1:0]];
                rd_stage.valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CLEAR;
            fill_cnt_q   <= '0;
            init_done_q  <= 1'b0;
            load_ready_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            init_done_q  <= init_done_d;
            load_ready_q <= load_ready_d;
            load_err_q   <= load_err_d;
        end
    end

    // NOTE: the RAM array has no reset; the CLEAR fill initialises it, and leaving the
    // reset off keeps it mappable to block RAM. The stage-0 read samples the pre-edge
    // word, which gives read-first behaviour on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_q[wr_idx] <= wr_data;
        end
    end

    imem_read_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .NOP_INSTR    (NOP_INSTR)
    ) u_read_pipe (
        .clk  (clk),
        .rst  (rst),
        .rd_i (rd_stage),
        .rd_o (rd_out)
    );

    assign imem_data_o  = rd_out.data;
    assign imem_valid_o = rd_out.valid;
    assign imem_fault_o = rd_out.fault;
    assign load_ready_o = load_ready_q;
    assign load_err_o   = load_err_q;
    assign init_done_o  = init_done_q;

endmodule
